fpu_addsub_issue: RTL and testbench
===================================

# fpu_addsub_issue

Request/response front end for the pipelined floating-point add/sub unit (`add_sub_main`). It accepts operand pairs over a valid/ready handshake and drives them into the fixed-latency, non-stallable adder pipeline. It tracks each operation's tag alongside the pipeline, captures results into a response FIFO, and returns them with IEEE-754 class flags over a second valid/ready handshake. Credit accounting guarantees the FIFO never overflows, so the adder never needs backpressure.

## Interface
- WIDTH, 32, operand/result width (binary32)
- RSLT_DLY, 5, adder latency in cycles from operand presentation to result
- TAG_BITS, 4, width of the request tag carried to the response
- FIFO_DEPTH, 8, response FIFO entries; also the maximum number of outstanding operations

- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_a, req_b  in  WIDTH  operands
- req_op  in  1  0 = add, 1 = subtract
- req_tag  in  TAG_BITS  opaque tag, returned unchanged
- fpu_a, fpu_b  out  WIDTH  to adder `a`/`b`
- fpu_op  out  1  to adder `operation_select`
- fpu_r  in  WIDTH  from adder `R`
- rsp_valid  out  1  response present at FIFO head
- rsp_ready  in  1  consumer takes response
- rsp_data  out  WIDTH  result
- rsp_tag  out  TAG_BITS  tag of the originating request
- rsp_nan, rsp_inf, rsp_zero  out  1  result class flags

## Operation
- Accept: `acc = req_valid & req_ready`. Pop: `pop = rsp_valid & rsp_ready`.
- Occupancy counter, 0..FIFO_DEPTH, counts accepted operations not yet popped (in pipeline plus in FIFO).
  - `+1` on `acc` only; `-1` on `pop` only; unchanged when both or neither occur.
- `req_ready = (occupancy < FIFO_DEPTH)`. It is a function of registered occupancy only; a same-cycle pop does not bypass into it.
- Operand path: `fpu_a/fpu_b/fpu_op` equal `req_a/req_b/req_op` combinationally when `acc`, and 0 otherwise.
- Tracking shift register: RSLT_DLY stages of {valid, tag}.
  - Stage 0 loads {acc, req_tag} every cycle.
  - Each stage shifts one position per cycle. The register never stalls.
- Capture: when the last stage is valid, `fpu_r` is written to the FIFO with its tag and class flags, computed at capture.
  - nan: exp = all ones and mant != 0. Any NaN is forwarded as-is; no re-canonicalisation here, since the adder already emits `CAN_NAN` 0x7FC00000.
  - inf: exp = all ones and mant = 0.
  - zero: exp = 0 and mant = 0 (±0).
- FIFO: first-word-fall-through. Write and pop in the same cycle are both honoured, including when the FIFO is full.
- By construction, a write never occurs while the FIFO is full. The FIFO asserts this as a design assertion.
- Responses return in request order. Tags are not interpreted.

## Timing
- Request accepted in cycle T:
  - operands are on `fpu_*` in cycle T;
  - `fpu_r` holds the result in cycle T+RSLT_DLY and is captured at the end of that cycle;
  - `rsp_valid` asserts in cycle T+RSLT_DLY+1 at the earliest.
- Throughput: one op per cycle while `rsp_ready` is held high. Steady-state occupancy is RSLT_DLY+1, which is ≤ FIFO_DEPTH, so there are no bubbles.
- With `rsp_ready` low, exactly FIFO_DEPTH requests are accepted. `req_ready` then stays 0 until the cycle after the first pop.
- Reset values: occupancy 0, tracking register all invalid, FIFO empty, `rsp_valid` 0, `rsp_data/rsp_tag/flags` 0, `fpu_*` 0. `req_ready` is 1 once `arst_n` is released.
- Reset mid-operation: all in-flight and queued operations are discarded. Stale `fpu_r` values arriving after reset release are never captured, because the tracking stages are invalid.
- `rsp_*` outputs hold stable while `rsp_valid & !rsp_ready`.

## Structure
- Shared package `fpu_pkg`:
  - constants `EXP_BITS`=8, `MANT_BITS`=23, `CAN_NAN`=32'h7FC00000;
  - typedef `fp_class_t` {nan, inf, zero};
  - function `fp_classify(logic [31:0])`.
- One sub-module: `fpu_rsp_fifo`, a parameterised synchronous FWFT FIFO (DEPTH, data = WIDTH+TAG_BITS+3), with full/empty outputs and an overflow assertion.
- Occupancy counter and tracking shift register live in the top level.

## Test plan
- Single op: a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0, tag=3, `rsp_ready`=1 -> `rsp_valid` in cycle T+6 with data 0x40400000, tag 3, all flags 0.
- NaN input: a=0x7F800001, b=0x3F800000 -> rsp_data 0x7FC00000, `rsp_nan`=1. Also: 1.0 − 1.0 -> 0x00000000 with `rsp_zero`=1.
- Backpressure: `rsp_ready`=0, `req_valid`=1 continuously -> exactly 8 accepts, then `req_ready`=0. Pop one -> `req_ready`=1 the next cycle. All 8 responses are returned in tag order 0..7.
- Streaming: 20 back-to-back requests with `rsp_ready`=1 -> `req_ready` never deasserts, 20 responses are returned in order, and the FIFO overflow assertion never fires.
- Simultaneous accept and pop at occupancy 8 -> no accept that cycle (`req_ready`=0). Simultaneous accept and pop at occupancy 3 -> occupancy stays 3.
- Reset mid-flight: 3 ops accepted, `arst_n` pulsed low 2 cycles later -> no `rsp_valid` ever appears for them, and occupancy is 0 after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point constants, class flags and the binary32 classifier.
package fpu_pkg;

    localparam int unsigned EXP_BITS  = 8;
    localparam int unsigned MANT_BITS = 23;
    localparam logic [31:0] CAN_NAN   = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Class of a binary32 value; sign is ignored so +/-0 and +/-inf both match.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        logic [EXP_BITS-1:0]  e;
        logic [MANT_BITS-1:0] m;
        fp_class_t            c;
        e      = x[30:23];
        m      = x[22:0];
        c.nan  = (&e) && (|m);
        c.inf  = (&e) && !(|m);
        c.zero = !(|e) && !(|m);
        return c;
    endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// First-word-fall-through response FIFO; empty head reads as zero.
module fpu_rsp_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 39
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_rd   = rd_en && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
        !(wr_en && full && !rd_en));

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/return front end for the fixed-latency add/sub pipeline with credit-based flow control.
module fpu_addsub_issue
    import fpu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RSLT_DLY   = 5,
    parameter int unsigned TAG_BITS   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    input  logic                req_op,
    input  logic [TAG_BITS-1:0] req_tag,
    output logic [WIDTH-1:0]    fpu_a,
    output logic [WIDTH-1:0]    fpu_b,
    output logic                fpu_op,
    input  logic [WIDTH-1:0]    fpu_r,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic [TAG_BITS-1:0] rsp_tag,
    output logic                rsp_nan,
    output logic                rsp_inf,
    output logic                rsp_zero
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = WIDTH + TAG_BITS + 3;

    logic                acc;
    logic                pop;
    logic [OCC_W-1:0]    occ;
    logic [RSLT_DLY-1:0] trk_vld;
    logic [TAG_BITS-1:0] trk_tag [RSLT_DLY];
    fp_class_t           cap_cls;
    logic [ENT_W-1:0]    wr_data;
    logic [ENT_W-1:0]    rd_data;
    logic                fifo_full;
    logic                fifo_empty;

    // Credits cover pipeline plus FIFO, so the adder never needs backpressure.
    assign req_ready = (occ < OCC_W'(FIFO_DEPTH));
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign fpu_a  = acc ? req_a  : '0;
    assign fpu_b  = acc ? req_b  : '0;
    assign fpu_op = acc && req_op;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ <= '0;
        end else if (acc && !pop) begin
            occ <= occ + OCC_W'(1);
        end else if (pop && !acc) begin
            occ <= occ - OCC_W'(1);
        end
    end

    // Tag/valid tracker runs in lockstep with the non-stallable adder.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            trk_vld <= '0;
            for (int i = 0; i < int'(RSLT_DLY); i++) trk_tag[i] <= '0;
        end else begin
            trk_vld[0] <= acc;
            trk_tag[0] <= req_tag;
            for (int i = 1; i < int'(RSLT_DLY); i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_tag[i] <= trk_tag[i-1];
            end
        end
    end

    assign cap_cls = fp_classify(32'(fpu_r));
    assign wr_data = {fpu_r, trk_tag[RSLT_DLY-1], cap_cls};

    fpu_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (ENT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (trk_vld[RSLT_DLY-1]),
        .wr_data (wr_data),
        .rd_en   (rsp_ready),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign {rsp_data, rsp_tag, rsp_nan, rsp_inf, rsp_zero} = rd_data;

    // A full FIFO implies every credit is held by a queued response.
    a_full_credit: assert property (@(posedge clk) disable iff (!arst_n)
        !fifo_full || (occ == OCC_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Randomized and directed bench for fpu_addsub_issue with a stub adder and a transaction-level model.
module tb_fpu_addsub_issue;

    localparam int FIFO_DEPTH = 8;
    localparam int RSLT_DLY   = 5;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_op = 1'b0;
    logic [3:0]  req_tag = '0;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_op;
    logic [31:0] fpu_r;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_nan;
    logic        rsp_inf;
    logic        rsp_zero;

    fpu_addsub_issue dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_op    (fpu_op),
        .fpu_r     (fpu_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_nan   (rsp_nan),
        .rsp_inf   (rsp_inf),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Class flags {nan, inf, zero} from exponent/mantissa arithmetic.
    function automatic logic [2:0] ref_flags(input logic [31:0] r);
        int unsigned e;
        int unsigned m;
        e = (r >> 23) % 256;
        m = r % (1 << 23);
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0};
    endfunction

    // Stand-in adder: exact for the directed cases, NaN-canonicalising, otherwise a cheap mix.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (ref_flags(a)[2] || ref_flags(b)[2]) return 32'h7FC0_0000;
        if (op && a == b) return 32'h0;
        if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (b == 32'h0) return a;
        return a ^ {b[30:0], op};
    endfunction

    // Adder pipeline stub: result of cycle T's operands appears on fpu_r in cycle T+RSLT_DLY.
    logic [31:0] pipe [RSLT_DLY];
    always @(posedge clk) begin
        pipe[0] <= ref_add(fpu_a, fpu_b, fpu_op);
        for (int i = 1; i < RSLT_DLY; i++) pipe[i] <= pipe[i-1];
    end
    assign fpu_r = pipe[RSLT_DLY-1];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic [2:0]  fl;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          occ_m = 0;
    int          cyc = 0;
    int          n_pop = 0;
    logic        held = 1'b0;
    logic [39:0] held_v;
    logic        acc_m;
    logic        pop_m;
    exp_t        e_new;

    // Transaction model: ordered queue of expected responses plus credit count.
    always @(negedge clk) begin
        if (!arst_n) begin
            q.delete();
            occ_m = 0;
            held  = 1'b0;
        end else begin
            cyc++;
            acc_m = req_valid && req_ready;
            pop_m = rsp_valid && rsp_ready;
            check("req_ready", 64'(req_ready), 64'(occ_m < FIFO_DEPTH));
            check("fpu_a", 64'(fpu_a), acc_m ? 64'(req_a) : 64'h0);
            check("fpu_b_op", 64'({fpu_b, fpu_op}), acc_m ? 64'({req_b, req_op}) : 64'h0);
            if (held)
                check("rsp_hold", 64'({rsp_valid, rsp_data, rsp_tag, rsp_nan, rsp_inf, rsp_zero}), 64'(held_v));
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'h0);
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(q[0].data));
                    check("rsp_tag_flags", 64'({rsp_tag, rsp_nan, rsp_inf, rsp_zero}), 64'({q[0].tag, q[0].fl}));
                    check("rsp_latency_min", 64'(cyc >= q[0].cyc + RSLT_DLY + 1), 64'h1);
                end
            end
            held   = rsp_valid && !rsp_ready;
            held_v = {1'b1, rsp_data, rsp_tag, rsp_nan, rsp_inf, rsp_zero};
            if (pop_m && q.size() != 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (acc_m) begin
                e_new.data = ref_add(req_a, req_b, req_op);
                e_new.tag  = req_tag;
                e_new.fl   = ref_flags(e_new.data);
                e_new.cyc  = cyc;
                q.push_back(e_new);
            end
            occ_m = occ_m + int'(acc_m) - int'(pop_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_a();
        case ($urandom_range(0, 5))
            0:       return 32'h7F80_0000;
            1:       return 32'hFF80_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h8000_0000;
            4:       return 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
            default: return $urandom();
        endcase
    endfunction

    task automatic rnd_req();
        req_a   = rnd_a();
        req_b   = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom();
        req_op  = 1'($urandom_range(0, 1));
        req_tag = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int k = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (k < 60 && (q.size() != 0 || rsp_valid)) begin
            tick();
            k++;
        end
        check("drain_done", 64'(q.size() == 0 && !rsp_valid), 64'h1);
    endtask

    // With responses blocked, count accepts until credits run out; tags follow accept order.
    task automatic fill_count(output int n);
        n = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_tag = 4'(n);
            req_a   = $urandom();
            req_b   = $urandom();
            @(negedge clk);
            if (req_ready) n++;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [3:0] tag, input logic [31:0] exp_d, input logic [2:0] exp_f);
        int k = 0;
        logic seen = 1'b0;
        req_a = a; req_b = b; req_op = op; req_tag = tag;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_accept", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_valid) seen = 1'b1;
        end
        check("single_latency", 64'(k), 64'(RSLT_DLY + 1));
        check("single_data", 64'(rsp_data), 64'(exp_d));
        check("single_tag_flags", 64'({rsp_tag, rsp_nan, rsp_inf, rsp_zero}), 64'({tag, exp_f}));
        tick();
    endtask

    int n_acc;
    int pops0;
    int n_seen;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", 64'(rsp_data), 64'h0);
        check("rst_rsp_tag_flags", 64'({rsp_tag, rsp_nan, rsp_inf, rsp_zero}), 64'h0);
        check("rst_fpu", 64'({fpu_a, fpu_op}), 64'h0);
        tick();
        arst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        tick();

        // Directed single operations
        single(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3, 32'h4040_0000, 3'b000);
        single(32'h7F80_0001, 32'h3F80_0000, 1'b0, 4'd5, 32'h7FC0_0000, 3'b100);
        single(32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd9, 32'h0000_0000, 3'b001);
        single(32'hFF80_0000, 32'h0000_0000, 1'b0, 4'd1, 32'hFF80_0000, 3'b010);
        drain();

        // Backpressure: exactly FIFO_DEPTH accepts, then accept+pop at full occupancy
        fill_count(n_acc);
        check("bp_accepts", 64'(n_acc), 64'(FIFO_DEPTH));
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_full_no_accept", 64'(req_ready), 64'h0);
        check("bp_head_tag0", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd0}));
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", 64'(req_ready), 64'h1);
        tick();
        rsp_ready = 1'b1;
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            @(negedge clk);
            check("bp_order", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'(i)}));
            tick();
        end
        drain();

        // Accept and pop together at occupancy 3 leaves occupancy 3
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        repeat (3) begin rnd_req(); tick(); end
        req_valid = 1'b0;
        repeat (6) tick();
        rnd_req();
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("occ3_both", 64'({req_ready, rsp_valid}), 64'h3);
        tick();
        fill_count(n_acc);
        check("occ3_remaining_credits", 64'(n_acc), 64'(FIFO_DEPTH - 3));
        drain();

        // Streaming: 20 back-to-back requests without bubbles
        pops0 = n_pop;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rnd_req();
            @(negedge clk);
            check("stream_ready", 64'(req_ready), 64'h1);
            tick();
        end
        drain();
        check("stream_count", 64'(n_pop - pops0), 64'd20);

        // Randomized handshakes on both sides
        for (int i = 0; i < 400; i++) begin
            rnd_req();
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with three operations in flight
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        repeat (3) begin rnd_req(); tick(); end
        req_valid = 1'b0;
        repeat (2) tick();
        arst_n = 1'b0;
        repeat (2) tick();
        arst_n = 1'b1;
        n_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) n_seen++;
            tick();
        end
        check("rstmid_no_rsp", 64'(n_seen), 64'h0);
        fill_count(n_acc);
        check("rstmid_occ_zero", 64'(n_acc), 64'(FIFO_DEPTH));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
